// File: rtl/cycle_seq_pkg.sv
// Shared constants and types for the picoMIPS multi-cycle sequencer.
// The one-hot cycle bit positions are also used by the register file.
package cycle_seq_pkg;

  localparam int CYCLE_SIZE  = 3;
  localparam int CYCLE_FETCH = 0;
  localparam int CYCLE_LOAD  = 1;
  localparam int CYCLE_EXEC  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    EXEC    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } seq_state_t;

  // IDLE and both WAIT states drive no cycle bit, so no write can happen there.
  function automatic logic [CYCLE_SIZE-1:0] cycle_of(input seq_state_t s);
    logic [CYCLE_SIZE-1:0] c;
    c = {CYCLE_SIZE{1'b0}};
    case (s)
      FETCH:   c[CYCLE_FETCH] = 1'b1;
      LOAD:    c[CYCLE_LOAD]  = 1'b1;
      EXEC:    c[CYCLE_EXEC]  = 1'b1;
      default: c = {CYCLE_SIZE{1'b0}};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cycle_seq_chk.sv
// Property checker for the sequencer outputs: at most one cycle bit is ever high.
module cycle_seq_chk
  import cycle_seq_pkg::*;
(
  input logic                  clk,
  input logic                  n_reset,
  input logic [CYCLE_SIZE-1:0] cycle
);

  a_cycle_onehot: assert property (@(posedge clk) disable iff (!n_reset) $onehot0(cycle));

endmodule

// File: rtl/cycle_seq_sync_ff.sv
// Multi-stage synchroniser that brings an asynchronous switch into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cycle_seq.sv
// FETCH/LOAD/EXEC sequencer with SW8 wait handshake and retired-instruction counter.
// Optional single-step button is enabled by defining SINGLE_STEP_EN.
module cycle_seq
  import cycle_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  run,
  input  logic                  sw8,
  input  logic                  wait_req,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [CYCLE_SIZE-1:0] cycle,
  output logic                  pc_en,
  output logic                  waiting,
  output logic [CNT_W-1:0]      retired
);

  logic run_s;
  logic sw8_s;
  logic start_s;

  seq_state_t            state_q, state_d;
  logic [CYCLE_SIZE-1:0] cycle_q, cycle_d;
  logic                  pc_en_q, pc_en_d;
  logic                  waiting_q, waiting_d;
  logic [CNT_W-1:0]      retired_q, retired_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (.clk(clk), .n_reset(n_reset), .d(run), .q(run_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw8 (.clk(clk), .n_reset(n_reset), .d(sw8), .q(sw8_s));

`ifdef SINGLE_STEP_EN
  logic step_s;
  logic step_prev_q, step_prev_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (.clk(clk), .n_reset(n_reset), .d(step), .q(step_s));

  // Edges only matter in IDLE; elsewhere they are consumed here and forgotten.
  always_comb begin
    step_prev_d = step_s;
    start_s     = run_s | (step_s & ~step_prev_q);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
    end
  end
`else
  always_comb begin
    start_s = run_s;
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = FETCH;
        else         state_d = IDLE;
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = EXEC;
      EXEC: begin
        if (wait_req) begin
          state_d = WAIT_HI;
        end else begin
          pc_en_d = 1'b1;
          state_d = run_s ? FETCH : IDLE;
        end
      end
      WAIT_HI: begin
        if (sw8_s) state_d = WAIT_LO;
        else       state_d = WAIT_HI;
      end
      // A switch already high on entry must be seen low before the handshake ends.
      WAIT_LO: begin
        if (!sw8_s) begin
          pc_en_d = 1'b1;
          state_d = run_s ? FETCH : IDLE;
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: state_d = IDLE;
    endcase

    cycle_d   = cycle_of(state_d);
    waiting_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    if (pc_en_d) retired_d = retired_q + CNT_W'(1);
    else         retired_d = retired_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cycle_q   <= {CYCLE_SIZE{1'b0}};
      pc_en_q   <= 1'b0;
      waiting_q <= 1'b0;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      pc_en_q   <= pc_en_d;
      waiting_q <= waiting_d;
      retired_q <= retired_d;
    end
  end

  assign cycle   = cycle_q;
  assign pc_en   = pc_en_q;
  assign waiting = waiting_q;
  assign retired = retired_q;

  cycle_seq_chk u_chk (.clk(clk), .n_reset(n_reset), .cycle(cycle_q));

endmodule

// File: tb/tb_cycle_seq.sv
// Self-checking bench for cycle_seq: instruction-level reference model plus directed pins.
module tb_cycle_seq;
  import cycle_seq_pkg::*;

  localparam int S = 2;
  localparam int W = 6;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic run = 1'b0;
  logic sw8 = 1'b0;
  logic wait_req = 1'b0;
`ifdef SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic [CYCLE_SIZE-1:0] cycle;
  logic                  pc_en;
  logic                  waiting;
  logic [W-1:0]          retired;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cycle_seq #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .run(run),
    .sw8(sw8),
    .wait_req(wait_req),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .cycle(cycle),
    .pc_en(pc_en),
    .waiting(waiting),
    .retired(retired)
  );

  // Reference model: an instruction in flight has a phase index (0..2) and a
  // handshake progress (0 none, 1 need high, 2 need low); switches seen S edges late.
  bit m_run[$];
  bit m_sw8[$];
  bit m_step[$];
  bit step_prev;
  int phase;
  int hs;
  int bitpos[3] = '{CYCLE_FETCH, CYCLE_LOAD, CYCLE_EXEC};
  logic [CYCLE_SIZE-1:0] exp_cycle;
  logic                  exp_pc;
  logic                  exp_wait;
  logic [W-1:0]          exp_ret;

  task automatic model_reset();
    m_run.delete();
    m_sw8.delete();
    m_step.delete();
    for (int i = 0; i < S; i++) begin
      m_run.push_back(1'b0);
      m_sw8.push_back(1'b0);
      m_step.push_back(1'b0);
    end
    step_prev = 1'b0;
    phase = -1;
    hs = 0;
    exp_cycle = '0;
    exp_pc = 1'b0;
    exp_wait = 1'b0;
    exp_ret = '0;
  endtask

  task automatic model_step();
    bit r, s8, sd, st_edge, finish, start;
    r = m_run.pop_front();
    m_run.push_back(run);
    s8 = m_sw8.pop_front();
    m_sw8.push_back(sw8);
    sd = m_step.pop_front();
`ifdef SINGLE_STEP_EN
    m_step.push_back(step);
`else
    m_step.push_back(1'b0);
`endif
    st_edge = sd & !step_prev;
    step_prev = sd;
    finish = 1'b0;
    start = 1'b0;
    exp_pc = 1'b0;
    if (hs == 1) begin
      if (s8) hs = 2;
    end else if (hs == 2) begin
      if (!s8) finish = 1'b1;
    end else if (phase == 2) begin
      if (wait_req) hs = 1;
      else finish = 1'b1;
    end else if (phase >= 0) begin
      phase++;
    end else begin
      start = r | st_edge;
    end
    if (finish) begin
      hs = 0;
      phase = -1;
      exp_pc = 1'b1;
      exp_ret = exp_ret + 1'b1;
      start = r;
    end
    if (start) phase = 0;
    exp_wait = (hs != 0);
    exp_cycle = (hs == 0 && phase >= 0) ? CYCLE_SIZE'(1 << bitpos[phase]) : '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge n_reset);
      if (!n_reset) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Every cycle out of reset, all outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset) begin
        check("model_cycle", 32'(cycle), 32'(exp_cycle));
        check("model_pc_en", 32'(pc_en), 32'(exp_pc));
        check("model_waiting", 32'(waiting), 32'(exp_wait));
        check("model_retired", 32'(retired), 32'(exp_ret));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input logic [CYCLE_SIZE-1:0] v, input string name, output int k);
    k = 0;
    while (cycle !== v && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(k < 40), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    n_reset = 1'b0;
    run = 1'b0;
    sw8 = 1'b0;
    wait_req = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(2);
    n_reset = 1'b1;
  endtask

  int k;

  initial begin
    tick(3);
    check("reset_cycle", 32'(cycle), 32'd0);
    check("reset_pc_en", 32'(pc_en), 32'd0);
    check("reset_waiting", 32'(waiting), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    n_reset = 1'b1;
    tick(2);

    // run held: FETCH appears S+1 edges after run is driven, then 10 retired in 30 cycles
    run = 1'b1;
    wait_cycle(3'b001, "first_fetch", k);
    check("fetch_latency", 32'(k), 32'(S + 1));
    tick(30);
    check("retired_after_30", 32'(retired), 32'd10);
    check("cycle_after_30", 32'(cycle), 32'b001);
    check("pc_en_after_30", 32'(pc_en), 32'd1);

    // wait handshake
    wait_req = 1'b1;
    k = 0;
    while (!waiting && k < 10) begin
      tick(1);
      k++;
    end
    wait_req = 1'b0;
    tick(20);
    check("wait_held", 32'(waiting), 32'd1);
    check("wait_cycle_zero", 32'(cycle), 32'd0);
    sw8 = 1'b1;
    tick(5);
    sw8 = 1'b0;
    wait_cycle(3'b001, "resume_fetch", k);
    check("resume_latency", 32'(k), 32'(S + 1));

    // run dropped in LOAD: work drains to IDLE, nothing aborted
    wait_cycle(3'b010, "load_seen", k);
    run = 1'b0;
    tick(12);
    check("drained_cycle", 32'(cycle), 32'd0);
    check("drained_waiting", 32'(waiting), 32'd0);

    // asynchronous reset in EXEC clears outputs before the next edge
    run = 1'b1;
    wait_cycle(3'b100, "exec_seen", k);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_cycle", 32'(cycle), 32'd0);
    check("async_pc_en", 32'(pc_en), 32'd0);
    check("async_waiting", 32'(waiting), 32'd0);
    check("async_retired", 32'(retired), 32'd0);
    run = 1'b0;
    #3;
    n_reset = 1'b1;
    tick(10);
    check("idle_after_reset", 32'(cycle), 32'd0);

    // counter wrap: 2^W instructions bring retired back to zero
    do_reset();
    run = 1'b1;
    wait_cycle(3'b001, "wrap_fetch", k);
    tick(3 * (1 << W));
    check("retired_wrap", 32'(retired), 32'd0);
    check("wrap_pc_en", 32'(pc_en), 32'd1);
    run = 1'b0;
    tick(10);

`ifdef SINGLE_STEP_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(3);
      step = 1'b0;
      tick(10);
    end
    check("step_three", 32'(retired), 32'd3);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    wait_cycle(3'b001, "step_fetch", k);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(15);
    check("step_ignored_busy", 32'(retired), 32'd4);
`endif

    // randomized phase with sticky switches and occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) sw8 = ~sw8;
      wait_req = ($urandom_range(0, 3) == 0);
`ifdef SINGLE_STEP_EN
      if ($urandom_range(0, 4) == 0) step = ~step;
`endif
      if ($urandom_range(0, 399) == 0) begin
        n_reset = 1'b0;
        tick($urandom_range(1, 3));
        n_reset = 1'b1;
      end else begin
        tick(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
